door_lock_ctrl: RTL
===================

// Module: door_lock_ctrl
// PURPOSE
//   Downstream stage of the password-check block. Consumes each pass/fail verdict and drives the door strike.
//   A pass opens the door for a timed window. MAX_FAIL consecutive fails trigger a timed lockout with an alarm pulse.
//   Also gates the synchronised enter pulse back toward the checker, so no new check can start while open or locked out.
// PARAMETERS
//   OPEN_CYCLES  50_000_000   cycles door_open is held per pass (1 s @ 50 MHz); must be >= 1
//   LOCK_CYCLES  250_000_000  cycles locked_out is held after lockout (5 s @ 50 MHz); must be >= 1
//   MAX_FAIL     3            consecutive fails that trigger lockout; must be >= 1
//   TIMER_W      28           timer width; must satisfy 2**TIMER_W > max(OPEN_CYCLES, LOCK_CYCLES)
//   FAIL_W       2            fail counter width; must satisfy 2**FAIL_W > MAX_FAIL
// PORTS
//   clk           in   1       system clock, rising edge
//   rst           in   1       synchronous reset, active-high
//   enter_in      in   1       one-cycle enter pulse from the one-shot synchroniser
//   enter_out     out  1       gated enter pulse to the checker
//   result_valid  in   1       one-cycle pulse: checker verdict ready
//   result_ok     in   1       verdict, sampled only when result_valid=1 (1 = password matched)
//   door_open     out  1       door strike drive
//   locked_out    out  1       lockout indicator
//   alarm         out  1       one-cycle pulse on lockout entry
//   fail_count    out  FAIL_W  current consecutive-fail count
// BEHAVIOUR
//   - All outputs are registered.
//   - Reset values: state=IDLE, timer=0, fail_count=0; door_open, locked_out, alarm and enter_out all 0.
//   - rst asserted in any state returns the block to those values on the next edge.
//   - Reset mid-open or mid-lockout aborts the window immediately.
//   - States: IDLE, OPEN, LOCKOUT.
//   - IDLE, result_valid & result_ok:
//       -> OPEN; timer <= OPEN_CYCLES-1; fail_count <= 0.
//   - IDLE, result_valid & !result_ok, fail_count+1 < MAX_FAIL:
//       -> stay IDLE; fail_count <= fail_count+1.
//   - IDLE, result_valid & !result_ok, fail_count+1 == MAX_FAIL:
//       -> LOCKOUT; timer <= LOCK_CYCLES-1; fail_count <= MAX_FAIL; alarm <= 1 for exactly 1 cycle.
//   - OPEN: door_open=1 in every OPEN cycle.
//       -> timer decrements each cycle; at timer==0 -> IDLE.
//       -> door_open is therefore high for exactly OPEN_CYCLES cycles, starting the cycle after the result_valid edge.
//   - LOCKOUT: locked_out=1 in every LOCKOUT cycle, for exactly LOCK_CYCLES cycles.
//       -> at timer==0 -> IDLE with fail_count <= 0.
//   - result_valid outside IDLE is ignored, including a result_valid coinciding with the timer==0 exit cycle.
//     The state, fail_count and outputs are unaffected.
//   - enter_out <= enter_in & (state==IDLE) & !(result_valid in the same cycle).
//       -> 1-cycle latency; pulses arriving during OPEN or LOCKOUT are dropped, not queued.
//   - A fail followed by a pass clears fail_count, so only consecutive fails count toward lockout.
//   - Arithmetic: timer and fail_count are unsigned.
//       -> fail_count never exceeds MAX_FAIL; timer never wraps.
// TESTING
//   (bench params: OPEN_CYCLES=4, LOCK_CYCLES=8, MAX_FAIL=3)
//   1. Reset, then result_valid=1 with result_ok=1 at edge N
//      -> door_open=1 at edges N+1..N+4, 0 at N+5; fail_count stays 0.
//   2. Fails, fail, pass -> fail_count goes 1, 2, then 0; no alarm; door opens for 4 cycles.
//   3. Three consecutive fails, last at edge N
//      -> alarm=1 only at N+1; locked_out=1 at N+1..N+8; fail_count=3 during lockout, 0 at N+9.
//   4. enter_in pulses during OPEN and during LOCKOUT -> enter_out stays 0.
//      An enter_in pulse in IDLE at edge M -> enter_out=1 at M+1 only.
//   5. result_valid=1 with ok=1 arriving on the cycle locked_out is last high
//      -> ignored; the block returns to IDLE with door_open=0.
//   6. rst=1 during OPEN (timer=2) and during LOCKOUT
//      -> next edge: all outputs 0, fail_count=0, state IDLE; a subsequent pass opens normally.

Source files
------------

// File: rtl/door_lock_ctrl.sv
// Door strike controller downstream of the password checker: timed open window on a pass,
// timed lockout with a one-cycle alarm after MAX_FAIL consecutive fails, and enter-pulse gating.
module door_lock_ctrl #(
  parameter int unsigned OPEN_CYCLES = 50_000_000,
  parameter int unsigned LOCK_CYCLES = 250_000_000,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned TIMER_W     = 28,
  parameter int unsigned FAIL_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enter_in,
  output logic              enter_out,
  input  logic              result_valid,
  input  logic              result_ok,
  output logic              door_open,
  output logic              locked_out,
  output logic              alarm,
  output logic [FAIL_W-1:0] fail_count
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPEN    = 2'd1,
    ST_LOCKOUT = 2'd2
  } state_t;

  localparam logic [TIMER_W-1:0] OPEN_LOAD = TIMER_W'(OPEN_CYCLES - 1);
  localparam logic [TIMER_W-1:0] LOCK_LOAD = TIMER_W'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0]  FAIL_MAX  = FAIL_W'(MAX_FAIL);
  // The fail that brings the count to MAX_FAIL is the one that locks out.
  localparam logic [FAIL_W-1:0]  FAIL_LAST = FAIL_W'(MAX_FAIL - 1);
  localparam logic [TIMER_W-1:0] TIMER_ZERO = {TIMER_W{1'b0}};

  state_t              state_r;
  logic [TIMER_W-1:0]  timer_r;
  logic [FAIL_W-1:0]   fail_cnt_r;

  assign fail_count = fail_cnt_r;

  // Single FSM register block: state, window timer, fail counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      timer_r    <= TIMER_ZERO;
      fail_cnt_r <= {FAIL_W{1'b0}};
      door_open  <= 1'b0;
      locked_out <= 1'b0;
      alarm      <= 1'b0;
      enter_out  <= 1'b0;
    end else begin
      alarm     <= 1'b0;
      enter_out <= enter_in & (state_r == ST_IDLE) & ~result_valid;
      case (state_r)
        ST_IDLE: begin
          if (result_valid) begin
            if (result_ok) begin
              state_r    <= ST_OPEN;
              timer_r    <= OPEN_LOAD;
              fail_cnt_r <= {FAIL_W{1'b0}};
              door_open  <= 1'b1;
            end else if (fail_cnt_r >= FAIL_LAST) begin
              state_r    <= ST_LOCKOUT;
              timer_r    <= LOCK_LOAD;
              fail_cnt_r <= FAIL_MAX;
              locked_out <= 1'b1;
              alarm      <= 1'b1;
            end else begin
              fail_cnt_r <= fail_cnt_r + FAIL_W'(1);
            end
          end
        end
        ST_OPEN: begin
          if (timer_r == TIMER_ZERO) begin
            state_r   <= ST_IDLE;
            door_open <= 1'b0;
          end else begin
            timer_r <= timer_r - TIMER_W'(1);
          end
        end
        ST_LOCKOUT: begin
          if (timer_r == TIMER_ZERO) begin
            state_r    <= ST_IDLE;
            locked_out <= 1'b0;
            fail_cnt_r <= {FAIL_W{1'b0}};
          end else begin
            timer_r <= timer_r - TIMER_W'(1);
          end
        end
        default: begin
          state_r    <= ST_IDLE;
          timer_r    <= TIMER_ZERO;
          fail_cnt_r <= {FAIL_W{1'b0}};
          door_open  <= 1'b0;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
